// File: rtl/sbox8_pini1_ctrl_if.sv
// sbox8_pini1_ctrl_if: handshake and share buses between the sbox controller, its
// upstream/downstream neighbours and the external 4-cycle masked sbox.
interface sbox8_pini1_ctrl_if;
    logic       in_valid, in_ready;
    logic [7:0] in_s1, in_s0, rnd;
    logic [7:0] sb_si1, sb_si0, sb_r, sb_bo1, sb_bo0;
    logic       out_valid, out_ready;
    logic [7:0] out_s1, out_s0;
    logic       busy;
    modport master (
        output in_valid, in_s1, in_s0, rnd, sb_bo1, sb_bo0, out_ready,
        input  in_ready, sb_si1, sb_si0, sb_r, out_valid, out_s1, out_s0, busy
    );
    modport slave (
        input  in_valid, in_s1, in_s0, rnd, sb_bo1, sb_bo0, out_ready,
        output in_ready, sb_si1, sb_si0, sb_r, out_valid, out_s1, out_s0, busy
    );
endinterface

// File: rtl/sbox8_pini1_ctrl.sv
// sbox8_pini1_ctrl: holds masked shares stable for a 4-cycle sbox and captures its result.
// Optional SBOX8_CTRL_PRNG_EN replaces the external rnd mask with an internal 16-bit LFSR.
module sbox8_pini1_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    sbox8_pini1_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, OUT} state_t;
    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] si1_q, si0_q, r_q, os1_q, os0_q;
    logic [7:0] mask;
    logic       accept, capture;

    assign bus.in_ready  = state_q == IDLE || (state_q == OUT && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign capture       = state_q == HOLD && cnt_q == 2'd3;
    assign bus.out_valid = state_q == OUT;
    assign bus.busy      = state_q == HOLD;
    assign bus.sb_si1    = si1_q;
    assign bus.sb_si0    = si0_q;
    assign bus.sb_r      = r_q;
    assign bus.out_s1    = os1_q;
    assign bus.out_s0    = os0_q;

`ifdef SBOX8_CTRL_PRNG_EN
    logic [15:0] lfsr_q;
    logic        unused_rnd;
    assign unused_rnd = ^bus.rnd;
    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_q <= 16'hACE1;
        else if (accept) lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign mask = lfsr_q[7:0];
`else
    assign mask = bus.rnd;
`endif

    always_comb begin
        state_d = accept ? HOLD : capture ? OUT : (state_q == OUT && bus.out_ready) ? IDLE : state_q;
        cnt_d   = accept ? 2'd0 : state_q == HOLD ? cnt_q + 2'd1 : cnt_q;
    end

    // Shares are only ever moved, never combined, so the unmasked byte never exists here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            si1_q   <= 8'h00;
            si0_q   <= 8'h00;
            r_q     <= 8'h00;
            os1_q   <= 8'h00;
            os0_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                si1_q <= bus.in_s1;
                si0_q <= bus.in_s0;
                r_q   <= mask;
            end
            if (capture) begin
                os1_q <= bus.sb_bo1;
                os0_q <= bus.sb_bo0;
            end
        end
    end
endmodule

// File: tb/tb_sbox8_pini1_ctrl.sv
// tb_sbox8_pini1_ctrl: randomized and directed bench for sbox8_pini1_ctrl with a
// behavioural controller model and a 4-cycle masked SKINNY sbox model.
module tb_sbox8_pini1_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sbox8_pini1_ctrl_if bus ();
    sbox8_pini1_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

`ifdef SBOX8_CTRL_PRNG_EN
    localparam logic [7:0] FIRST_MASK = 8'hE1;
`else
    localparam logic [7:0] FIRST_MASK = 8'h3C;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mix(input logic [7:0] x);
        return (~(((x >> 1) | x) >> 2) & 8'h11) ^ x;
    endfunction
    function automatic logic [7:0] perm(input logic [7:0] x);
        return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
               ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    endfunction
    function automatic logic [7:0] skinny(input logic [7:0] v);
        logic [7:0] x;
        x = mix(v);
        for (int i = 0; i < 3; i++) x = mix(perm(x));
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    // External sbox: result (masked by sb_r) only valid once inputs held for 4 cycles
    logic [23:0] sb_prev;
    int age = 0;
    always @(negedge clk) begin
        if ({bus.sb_si1, bus.sb_si0, bus.sb_r} !== sb_prev) age = 0;
        else age++;
        sb_prev = {bus.sb_si1, bus.sb_si0, bus.sb_r};
        if (age >= 3) begin
            bus.sb_bo1 = skinny(bus.sb_si1 ^ bus.sb_si0) ^ bus.sb_r;
            bus.sb_bo0 = bus.sb_r;
        end else begin
            bus.sb_bo1 = 8'($urandom);
            bus.sb_bo0 = 8'($urandom);
        end
    end

    // Controller model: one byte in flight, result presented 5 cycles after acceptance
    logic       m_hold, e_ir, acc_m;
    int         m_left;
    logic [7:0] m_x1, m_x0, m_r, m_o1, m_o0, p_o1, p_o0, mk;
    logic [15:0] m_lfsr;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_hold = 0; m_left = 0; m_lfsr = 16'hACE1;
            m_x1 = 0; m_x0 = 0; m_r = 0; m_o1 = 0; m_o0 = 0; p_o1 = 0; p_o0 = 0;
        end
        e_ir = m_left == 0 && (!m_hold || bus.out_ready);
        chk("in_ready", bus.in_ready, e_ir);
        chk("out_valid", bus.out_valid, m_hold);
        chk("busy", bus.busy, m_left != 0);
        chk("sb_si1", bus.sb_si1, m_x1);
        chk("sb_si0", bus.sb_si0, m_x0);
        chk("sb_r", bus.sb_r, m_r);
        if (m_hold || !rst_n) begin
            chk("out_s1", bus.out_s1, m_o1);
            chk("out_s0", bus.out_s0, m_o0);
        end
        if (rst_n) begin
            acc_m = bus.in_valid && e_ir;
            if (m_hold && bus.out_ready) m_hold = 0;
            if (acc_m) begin
`ifdef SBOX8_CTRL_PRNG_EN
                mk = m_lfsr[7:0];
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`else
                mk = bus.rnd;
`endif
                m_x1 = bus.in_s1; m_x0 = bus.in_s0; m_r = mk;
                p_o1 = skinny(bus.in_s1 ^ bus.in_s0) ^ mk;
                p_o0 = mk;
                m_left = 4;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hold = 1; m_o1 = p_o1; m_o0 = p_o0;
                end
            end
        end
    end

    task automatic wait_out(output int lat);
        int t0;
        t0 = cyc;
        lat = -1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        bus.out_ready = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = cyc - t0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat, seen, guard;
        logic acc;
        logic [7:0] s1, xb;
        bus.in_valid = 0; bus.in_s1 = 0; bus.in_s0 = 0; bus.rnd = 0; bus.out_ready = 0;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        bus.in_s1 = 8'h00; bus.in_s0 = 8'h00; bus.rnd = 8'h3C; bus.in_valid = 1;
        wait_out(lat);
        chk("lat_first", lat, 5);
        chk("xor_first", bus.out_s1 ^ bus.out_s0, 8'h65);
        chk("mask_first", bus.sb_r, FIRST_MASK);
        chk("out_s0_first", bus.out_s0, FIRST_MASK);
        @(posedge clk); #1;
        bus.out_ready = 1; bus.in_valid = 1; bus.in_s1 = 8'hA5; bus.in_s0 = 8'h5A; bus.rnd = 8'h96;
        wait_out(lat);
        chk("lat_second", lat, 5);
        chk("xor_second", bus.out_s1 ^ bus.out_s0, 8'hFF);
        chk("si1_second", bus.sb_si1, 8'hA5);
        chk("si0_second", bus.sb_si0, 8'h5A);
`ifdef SBOX8_CTRL_PRNG_EN
        chk("mask_second", bus.sb_r, 8'h70);
`endif
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_xor", bus.out_s1 ^ bus.out_s0, 8'hFF);
            @(posedge clk); #1;
            bus.in_valid = 1; bus.in_s1 = 8'h12; bus.in_s0 = 8'h34; bus.rnd = 8'h5B;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1;
        @(negedge clk);
        chk("b2b_in_ready", bus.in_ready, 1);
        wait_out(lat);
        chk("lat_b2b", lat, 5);
        @(posedge clk); #1;
        bus.out_ready = 1; bus.in_valid = 1; bus.in_s1 = 8'($urandom); bus.in_s0 = 8'($urandom);
        @(posedge clk); #1;
        bus.in_valid = 0; bus.out_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("abort_si1", bus.sb_si1, 0);
        chk("abort_si0", bus.sb_si0, 0);
        chk("abort_r", bus.sb_r, 0);
        chk("abort_out_s1", bus.out_s1, 0);
        chk("abort_out_s0", bus.out_s0, 0);
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst_n = 1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("abort_no_out", seen, 0);
        @(posedge clk); #1;
        for (int x = 0; x < 256; x++) begin
            s1 = 8'($urandom);
            xb = 8'(x);
            bus.in_s1 = s1; bus.in_s0 = s1 ^ xb; bus.rnd = 8'($urandom); bus.in_valid = 1;
            guard = 0;
            do begin
                bus.out_ready = $urandom_range(0, 3) != 0;
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!acc && guard < 40);
            chk("sweep_accept", acc, 1);
            bus.in_valid = 0;
            repeat ($urandom_range(0, 2)) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        bus.out_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sbox8_pini1_ctrl.md
SBOX8_PINI1_CTRL -- requirements
Module: sbox8_pini1_ctrl

Interface
- REQ-001: clk  input  1  system clock; all state updates on rising edge.
- REQ-002: rst_n  input  1  asynchronous, active-low reset.
- REQ-003: in_valid  input  1  upstream offers a shared byte.
- REQ-004: in_ready  output  1  controller accepts a byte this cycle.
- REQ-005: in_s1  input  8  share 1 of the input byte.
- REQ-006: in_s0  input  8  share 0 of the input byte.
- REQ-007: rnd  input  8  external refresh randomness; used only without SBOX8_CTRL_PRNG_EN.
- REQ-008: sb_si1  output  8  share 1 driven to the 4-cycle non-pipelined masked sbox.
- REQ-009: sb_si0  output  8  share 0 driven to the sbox.
- REQ-010: sb_r  output  8  refresh mask driven to the sbox.
- REQ-011: sb_bo1  input  8  sbox output share 1.
- REQ-012: sb_bo0  input  8  sbox output share 0.
- REQ-013: out_valid  output  1  captured output shares are valid.
- REQ-014: out_ready  input  1  downstream consumes output this cycle.
- REQ-015: out_s1 / out_s0  output  8 each  captured output shares.
- REQ-016: busy  output  1  high in HOLD state.

Function
- REQ-017: FSM states: IDLE, HOLD, OUT; 2-bit hold counter cnt.
- REQ-018: in_ready SHALL be 1 in IDLE, and in OUT when out_ready=1; 0 otherwise (always 0 in HOLD).
- REQ-019: On accept (in_valid & in_ready), sb_si1/sb_si0/sb_r registers SHALL load in_s1/in_s0/mask; state goes to HOLD; cnt goes to 0.
- REQ-020: sb_si1, sb_si0 and sb_r SHALL be register outputs and SHALL NOT change in HOLD or OUT; they change only on accept.
- REQ-021: In HOLD, cnt SHALL increment each cycle; on the cycle with cnt=3, out_s1/out_s0 SHALL capture sb_bo1/sb_bo0 at that clock edge and state goes to OUT.
- REQ-022: Latency: out_valid SHALL rise 5 cycles after the accept edge (1 load cycle plus 4 hold cycles).
- REQ-023: out_valid SHALL be 1 exactly in OUT; out_s1/out_s0 stay stable while out_valid=1 and out_ready=0.
- REQ-024: In OUT with out_ready=1 and in_valid=0, state goes to IDLE.
- REQ-025: In OUT with out_ready=1 and in_valid=1, the output SHALL be consumed and the new byte accepted in the same cycle; state goes directly to HOLD (back-to-back throughput: one byte per 5 cycles).
- REQ-026: The unmasked value SHALL never be formed; shares are never XORed together inside the block.
- REQ-027: In IDLE, sb_* registers SHALL retain their last values (no toggling).

Reset
- REQ-028: rst_n=0 SHALL asynchronously force state IDLE, cnt=0, and sb_si1, sb_si0, sb_r, out_s1, out_s0 to 0x00; out_valid=0, busy=0, in_ready=1 after release.
- REQ-029: Reset asserted mid-HOLD or mid-OUT SHALL abort the byte; no output is produced for it.

Configuration
- REQ-030: Macro SBOX8_CTRL_PRNG_EN. When defined: the mask comes from an internal 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), reset seed 0xACE1, mask = LFSR[7:0], advanced once per accept; rnd is ignored. When undefined: mask = rnd sampled at accept; no LFSR is present.

Verification
- REQ-031: Reset, then in_s1=0x00, in_s0=0x00, rnd=0x3C, accept -> out_valid rises 5 cycles later; out_s1^out_s0=0x65.
- REQ-032: in_s1=0xA5, in_s0=0x5A, accept -> out_s1^out_s0=0xFF; sb_si*/sb_r stable for all 5 cycles.
- REQ-033: Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> HOLD entered the same cycle, next out_valid 5 cycles later.
- REQ-034: Assert rst_n=0 during HOLD cnt=2 -> all outputs 0x00, out_valid never rises for that byte.
- REQ-035: With SBOX8_CTRL_PRNG_EN, first two accepts after reset -> sb_r=0xE1, then the LFSR's next low byte; rnd toggling has no effect.
- REQ-036: 256-value sweep with random shares/masks -> out_s1^out_s0 equals the SKINNY 8-bit S-box for every input.
